full_adder: RTL and testbench

FULL_ADDER -- requirements
Module: full_adder

---
 rtl/full_adder_pkg.sv | 26 ++
 rtl/full_adder_cell.sv | 13 +
 rtl/full_adder.sv | 90 +++++++++
 tb/tb_full_adder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// Shared constants and reference arithmetic for the full_adder slice.
package full_adder_pkg;

  localparam int MAX_WIDTH = 64;

  // Reference {cout, sum}: operands masked to width bits, result width+1 bits.
  function automatic logic [MAX_WIDTH:0] ref_sum(
    input logic [MAX_WIDTH-1:0] a,
    input logic [MAX_WIDTH-1:0] b,
    input logic                 cin,
    input int                   width
  );
    logic [MAX_WIDTH:0] ma;
    logic [MAX_WIDTH:0] mb;
    ma = '0;
    mb = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) begin
        ma[i] = a[i];
        mb[i] = b[i];
      end
    end
    return ma + mb + {{MAX_WIDTH{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One combinational 1-bit full-adder stage.
module full_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder, one-cycle latency.
// Optional overflow flag: define FULL_ADDER_OVF_EN.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] s;

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             vld_q;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a_i   (a[i]),
      .b_i   (b[i]),
      .cin_i (carry[i]),
      .sum_o (s[i]),
      .cout_o(carry[i+1])
    );
  end

  // Result registers hold while no new operands arrive.
  always_comb begin
    sum_d  = sum_q;
    cout_d = cout_q;
    if (in_valid) begin
      sum_d  = s;
      cout_d = carry[WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      vld_q  <= in_valid;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = vld_q;

`ifdef FULL_ADDER_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) begin
      ovf_d = (a[WIDTH-1] == b[WIDTH-1]) &&
              (s[WIDTH-1] != a[WIDTH-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH 1, 8 and 16.
module tb_full_adder;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  logic clk;
  logic rst_n;

  logic       v1, a1, b1, c1;
  logic       s1, co1, ov1;

  logic       v8, c8;
  logic [7:0] a8, b8, s8;
  logic       co8, ov8;

  logic        v16, c16;
  logic [15:0] a16, b16, s16;
  logic        co16, ov16;

`ifdef FULL_ADDER_OVF_EN
  logic       f1, f8, f16;
`endif

  int n_tests;
  int n_fail;

  full_adder #(.WIDTH(1)) u1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (v1),
    .a        (a1),
    .b        (b1),
    .cin      (c1),
    .sum      (s1),
    .cout     (co1),
    .out_valid(ov1)
`ifdef FULL_ADDER_OVF_EN
    ,
    .ovf      (f1)
`endif
  );

  full_adder #(.WIDTH(8)) u8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (v8),
    .a        (a8),
    .b        (b8),
    .cin      (c8),
    .sum      (s8),
    .cout     (co8),
    .out_valid(ov8)
`ifdef FULL_ADDER_OVF_EN
    ,
    .ovf      (f8)
`endif
  );

  full_adder #(.WIDTH(16)) u16 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (v16),
    .a        (a16),
    .b        (b16),
    .cin      (c16),
    .sum      (s16),
    .cout     (co16),
    .out_valid(ov16)
`ifdef FULL_ADDER_OVF_EN
    ,
    .ovf      (f16)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t t1[8];
  vec_t t8[7];

  initial begin
    int          nvalid;
    int          cyc;
    logic        pv;
    logic [16:0] ref17;
    logic        refov;
    int          ss;
    logic        rv;
    logic [15:0] ra, rb;
    logic        rc;

    n_tests = 0;
    n_fail  = 0;

    t1[0] = '{8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0};
    t1[1] = '{8'd0, 8'd0, 1'b1, 8'd1, 1'b0, 1'b0};
    t1[2] = '{8'd0, 8'd1, 1'b0, 8'd1, 1'b0, 1'b0};
    t1[3] = '{8'd0, 8'd1, 1'b1, 8'd0, 1'b1, 1'b0};
    t1[4] = '{8'd1, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0};
    t1[5] = '{8'd1, 8'd0, 1'b1, 8'd0, 1'b1, 1'b0};
    t1[6] = '{8'd1, 8'd1, 1'b0, 8'd0, 1'b1, 1'b0};
    t1[7] = '{8'd1, 8'd1, 1'b1, 8'd1, 1'b1, 1'b0};

    t8[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    t8[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    t8[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    t8[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    t8[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    t8[5] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
    t8[6] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};

    rst_n = 1'b0;
    v1 = 0; a1 = 0; b1 = 0; c1 = 0;
    v8 = 0; a8 = 0; b8 = 0; c8 = 0;
    v16 = 0; a16 = 0; b16 = 0; c16 = 0;

    #3;
    chk("rst_sum8", 64'(s8), 64'h0);
    chk("rst_cout8", 64'(co8), 64'h0);
    chk("rst_vld8", 64'(ov8), 64'h0);
    chk("rst_vld1", 64'(ov1), 64'h0);
    chk("rst_vld16", 64'(ov16), 64'h0);
`ifdef FULL_ADDER_OVF_EN
    chk("rst_ovf8", 64'(f8), 64'h0);
`endif

    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();

    // WIDTH=1 truth table, back-to-back
    for (int i = 0; i < 8; i++) begin
      v1 = 1'b1;
      a1 = t1[i].a[0];
      b1 = t1[i].b[0];
      c1 = t1[i].c;
      tick();
      chk($sformatf("w1_sum[%0d]", i), 64'(s1), 64'(t1[i].s[0]));
      chk($sformatf("w1_cout[%0d]", i), 64'(co1), 64'(t1[i].co));
      chk($sformatf("w1_vld[%0d]", i), 64'(ov1), 64'h1);
    end
    v1 = 1'b0;

    // WIDTH=8 boundary and overflow vectors, back-to-back
    for (int i = 0; i < 7; i++) begin
      v8 = 1'b1;
      a8 = t8[i].a;
      b8 = t8[i].b;
      c8 = t8[i].c;
      tick();
      chk($sformatf("w8_sum[%0d]", i), 64'(s8), 64'(t8[i].s));
      chk($sformatf("w8_cout[%0d]", i), 64'(co8), 64'(t8[i].co));
      chk($sformatf("w8_vld[%0d]", i), 64'(ov8), 64'h1);
`ifdef FULL_ADDER_OVF_EN
      chk($sformatf("w8_ovf[%0d]", i), 64'(f8), 64'(t8[i].ov));
`endif
    end

    // Hold: one op then three idle clocks
    v8 = 1'b1; a8 = 8'd3; b8 = 8'd4; c8 = 1'b0;
    tick();
    chk("hold_sum0", 64'(s8), 64'h07);
    chk("hold_vld0", 64'(ov8), 64'h1);
    v8 = 1'b0; a8 = 8'hEE; b8 = 8'h11; c8 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("hold_sum%0d", i), 64'(s8), 64'h07);
      chk($sformatf("hold_cout%0d", i), 64'(co8), 64'h0);
      chk($sformatf("hold_vld%0d", i), 64'(ov8), 64'h0);
    end

    // Reset while a result is pending
    v8 = 1'b1; a8 = 8'hF0; b8 = 8'h20; c8 = 1'b0;
    tick();
    chk("pre_rst_sum", 64'(s8), 64'h10);
    a8 = 8'h0A; b8 = 8'h14;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sum", 64'(s8), 64'h0);
    chk("mid_rst_cout", 64'(co8), 64'h0);
    chk("mid_rst_vld", 64'(ov8), 64'h0);
    v8 = 1'b0;
    tick();
    chk("rst_edge_vld", 64'(ov8), 64'h0);
    chk("rst_edge_sum", 64'(s8), 64'h0);
    #2 rst_n = 1'b1;
    v8 = 1'b1; a8 = 8'h12; b8 = 8'h34; c8 = 1'b1;
    tick();
    chk("post_rst_sum", 64'(s8), 64'h47);
    chk("post_rst_vld", 64'(ov8), 64'h1);
    v8 = 1'b0;
    tick();
    chk("post_rst_drop", 64'(ov8), 64'h0);

    // WIDTH=16 random ops with gaps vs arithmetic model
    nvalid = 0;
    cyc    = 0;
    pv     = 1'b0;
    ref17  = '0;
    refov  = 1'b0;
    while (nvalid < 1000 && cyc < 5000) begin
      rv = ($urandom_range(0, 3) != 0);
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      case ($urandom_range(0, 9))
        0: begin ra = 16'hFFFF; rb = 16'hFFFF; rc = 1'b1; end
        1: begin ra = 16'h0000; rb = 16'h0000; rc = 1'b0; end
        2: begin ra = 16'h7FFF; rb = 16'h0000; end
        default: ;
      endcase
      v16 = rv; a16 = ra; b16 = rb; c16 = rc;
      if (rv) begin
        nvalid++;
        ref17 = 17'(int'(ra) + int'(rb) + int'(rc));
        ss = int'($signed(ra)) + int'($signed(rb)) + int'(rc);
        refov = (ss > 32767) || (ss < -32768);
      end
      pv = rv;
      tick();
      cyc++;
      chk("rnd_vld", 64'(ov16), 64'(pv));
      chk("rnd_sum", 64'({co16, s16}), 64'(ref17));
`ifdef FULL_ADDER_OVF_EN
      chk("rnd_ovf", 64'(f16), 64'(refov));
`endif
    end
    chk("rnd_count", 64'(nvalid), 64'd1000);
    v16 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
